// File: rtl/micro_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : micro_sequencer
// Brief   : Microprogrammed sequencer: uPC, return stack, next-address logic
//           and registered datapath control word for the mARC control unit.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module micro_sequencer #(
  parameter int CW_WIDTH    = 20,
  parameter int UADDR_WIDTH = 8,
  parameter int STACK_DEPTH = 4,
  parameter int IR_WIDTH    = 16,
  parameter int OPC_LSB     = 11,
  parameter int OPC_WIDTH   = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [UADDR_WIDTH-1:0]          ucode_addr,
  input  logic [CW_WIDTH+6+UADDR_WIDTH-1:0] ucode_data,
  input  logic [IR_WIDTH-1:0]             ir,
  input  logic [4:0]                      status,
  input  logic                            mem_ready,
  input  logic                            stall,
  output logic [CW_WIDTH-1:0]             ctrlword,
  output logic                            halted,
  output logic                            err
);

  localparam int c_SP_WIDTH = $clog2(STACK_DEPTH + 1);
  localparam logic [c_SP_WIDTH-1:0] c_DEPTH = c_SP_WIDTH'(STACK_DEPTH);

  localparam logic [2:0] c_SEQ_NEXT     = 3'b000;
  localparam logic [2:0] c_SEQ_BRANCH   = 3'b001;
  localparam logic [2:0] c_SEQ_CALL     = 3'b010;
  localparam logic [2:0] c_SEQ_RET      = 3'b011;
  localparam logic [2:0] c_SEQ_DISPATCH = 3'b100;
  localparam logic [2:0] c_SEQ_WAIT     = 3'b101;
  localparam logic [2:0] c_SEQ_HALT     = 3'b110;

  logic [UADDR_WIDTH-1:0] r_upc;
  logic [CW_WIDTH-1:0]    r_ctrlword;
  logic                   r_halted;
  logic                   r_err;
  logic [c_SP_WIDTH-1:0]  r_sp;
  logic [UADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [CW_WIDTH-1:0]    w_ctrl;
  logic [2:0]             w_seq;
  logic [2:0]             w_cond_sel;
  logic [UADDR_WIDTH-1:0] w_target;
  logic [OPC_WIDTH-1:0]   w_opcode;
  logic                   w_z, w_n, w_v, w_c, w_irq;
  logic                   w_cond;
  logic [UADDR_WIDTH-1:0] w_upc_inc;
  logic [UADDR_WIDTH-1:0] w_top;
  logic [UADDR_WIDTH-1:0] w_next_upc;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_err_set;
  logic                   w_halt_set;
  logic                   w_unused_ir;

  assign w_ctrl     = ucode_data[UADDR_WIDTH+6 +: CW_WIDTH];
  assign w_seq      = ucode_data[UADDR_WIDTH+3 +: 3];
  assign w_cond_sel = ucode_data[UADDR_WIDTH   +: 3];
  assign w_target   = ucode_data[0 +: UADDR_WIDTH];
  assign w_opcode   = ir[OPC_LSB +: OPC_WIDTH];
  assign w_unused_ir = ^ir;

  assign {w_irq, w_c, w_v, w_n, w_z} = status;
  assign w_upc_inc = r_upc + UADDR_WIDTH'(1);

  always_comb begin
    w_cond = 1'b0;
    case (w_cond_sel)
      3'b000:  w_cond = 1'b1;
      3'b001:  w_cond = w_z;
      3'b010:  w_cond = ~w_z;
      3'b011:  w_cond = w_n ^ w_v;
      3'b100:  w_cond = ~(w_n ^ w_v) & ~w_z;
      3'b101:  w_cond = w_c;
      3'b110:  w_cond = w_v;
      default: w_cond = w_irq;
    endcase
  end

  // Top of stack is the entry just below sp; a compare-mux avoids out-of-range indexing.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_sp == c_SP_WIDTH'(i + 1)) w_top = r_stack[i];
    end
  end

  always_comb begin
    w_next_upc = w_upc_inc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_err_set  = 1'b0;
    w_halt_set = 1'b0;
    if (r_halted) begin
      w_next_upc = r_upc;
    end else begin
      case (w_seq)
        c_SEQ_NEXT: ;
        c_SEQ_BRANCH: if (w_cond) w_next_upc = w_target;
        c_SEQ_CALL: begin
          if (w_cond) begin
            w_next_upc = w_target;
            if (r_sp == c_DEPTH) w_err_set = 1'b1;
            else                 w_push    = 1'b1;
          end
        end
        c_SEQ_RET: begin
          if (w_cond) begin
            if (r_sp == '0) begin
              w_next_upc = '0;
              w_err_set  = 1'b1;
            end else begin
              w_next_upc = w_top;
              w_pop      = 1'b1;
            end
          end
        end
        c_SEQ_DISPATCH: w_next_upc = w_target + UADDR_WIDTH'(w_opcode);
        c_SEQ_WAIT: if (!mem_ready) w_next_upc = r_upc;
        c_SEQ_HALT: begin
          w_next_upc = r_upc;
          w_halt_set = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upc      <= '0;
      r_ctrlword <= '0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
      r_sp       <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (stall) begin
      r_ctrlword <= '0;
    end else begin
      r_upc      <= w_next_upc;
      r_ctrlword <= w_ctrl;
      r_err      <= r_err | w_err_set;
      r_halted   <= r_halted | w_halt_set;
      if (w_push) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (r_sp == c_SP_WIDTH'(i)) r_stack[i] <= w_upc_inc;
        end
        r_sp <= r_sp + c_SP_WIDTH'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - c_SP_WIDTH'(1);
      end
    end
  end

  assign ucode_addr = r_upc;
  assign ctrlword   = r_ctrlword;
  assign halted     = r_halted;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_micro_sequencer
// Brief   : Directed self-checking bench for micro_sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  ucode_addr;
  logic [33:0] ucode_data;
  logic [15:0] ir;
  logic [4:0]  status;
  logic        mem_ready;
  logic        stall;
  logic [19:0] ctrlword;
  logic        halted;
  logic        err;

  logic [33:0] mem [256];
  int n_cmp;
  int n_fail;

  micro_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .ucode_addr(ucode_addr),
    .ucode_data(ucode_data),
    .ir        (ir),
    .status    (status),
    .mem_ready (mem_ready),
    .stall     (stall),
    .ctrlword  (ctrlword),
    .halted    (halted),
    .err       (err)
  );

  assign ucode_data = mem[ucode_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] cw(input int a);
    return 20'(32'hA5000 + a);
  endfunction

  function automatic logic [33:0] mk(input int a, input logic [2:0] seq,
                                     input logic [2:0] cond, input logic [7:0] tgt);
    return {cw(a), seq, cond, tgt};
  endfunction

  task automatic fill_next();
    for (int i = 0; i < 256; i++) mem[i] = mk(i, 3'b000, 3'b000, 8'h00);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fill_next();
    rst = 1'b1; ir = '0; status = '0; mem_ready = 1'b0; stall = 1'b0;
    step(2);
    n_cmp++; if (ucode_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", ucode_addr); end
    n_cmp++; if (ctrlword !== 20'h0) begin n_fail++; $display("FAIL rst_ctrlword: got %h want 0", ctrlword); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    for (int i = 0; i <= 256; i++) begin
      n_cmp++;
      if (ucode_addr !== 8'(i)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, ucode_addr, 8'(i)); end
      n_cmp++;
      if (ctrlword !== ((i == 0) ? 20'h0 : cw((i - 1) % 256))) begin
        n_fail++; $display("FAIL wrap_ctrlword[%0d]: got %h want %h", i, ctrlword, (i == 0) ? 20'h0 : cw((i - 1) % 256));
      end
      step(1);
    end
  endtask

  task automatic test_branch();
    fill_next();
    mem[5] = mk(5, 3'b001, 3'b001, 8'h40);
    status = 5'b00001;
    do_reset(); step(5);
    n_cmp++; if (ucode_addr !== 8'h05) begin n_fail++; $display("FAIL br_reach: got %h want 05", ucode_addr); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h40) begin n_fail++; $display("FAIL br_z_taken: got %h want 40", ucode_addr); end
    status = 5'b00000;
    do_reset(); step(6);
    n_cmp++; if (ucode_addr !== 8'h06) begin n_fail++; $display("FAIL br_z_not: got %h want 06", ucode_addr); end
    mem[5] = mk(5, 3'b001, 3'b100, 8'h40);
    status = 5'b00110;
    do_reset(); step(6);
    n_cmp++; if (ucode_addr !== 8'h40) begin n_fail++; $display("FAIL br_gt_taken: got %h want 40", ucode_addr); end
    status = 5'b00111;
    do_reset(); step(6);
    n_cmp++; if (ucode_addr !== 8'h06) begin n_fail++; $display("FAIL br_gt_not: got %h want 06", ucode_addr); end
    status = 5'b00000;
  endtask

  task automatic test_call_ret();
    fill_next();
    mem[8'h10] = mk(8'h10, 3'b010, 3'b000, 8'h20);
    mem[8'h20] = mk(8'h20, 3'b010, 3'b000, 8'h30);
    mem[8'h30] = mk(8'h30, 3'b010, 3'b000, 8'h40);
    mem[8'h40] = mk(8'h40, 3'b010, 3'b000, 8'h50);
    mem[8'h50] = mk(8'h50, 3'b011, 3'b000, 8'h00);
    mem[8'h41] = mk(8'h41, 3'b011, 3'b000, 8'h00);
    mem[8'h31] = mk(8'h31, 3'b011, 3'b000, 8'h00);
    mem[8'h21] = mk(8'h21, 3'b011, 3'b000, 8'h00);
    mem[8'h11] = mk(8'h11, 3'b011, 3'b000, 8'h00);
    do_reset(); step(16 + 4);
    n_cmp++; if (ucode_addr !== 8'h50) begin n_fail++; $display("FAIL call_depth4: got %h want 50", ucode_addr); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h41) begin n_fail++; $display("FAIL ret1: got %h want 41", ucode_addr); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h31) begin n_fail++; $display("FAIL ret2: got %h want 31", ucode_addr); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h21) begin n_fail++; $display("FAIL ret3: got %h want 21", ucode_addr); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h11) begin n_fail++; $display("FAIL ret4: got %h want 11", ucode_addr); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ret_err_clear: got %b want 0", err); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h00) begin n_fail++; $display("FAIL underflow_addr: got %h want 00", ucode_addr); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", err); end
    step(3);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end

    mem[8'h50] = mk(8'h50, 3'b010, 3'b000, 8'h70);
    mem[8'h70] = mk(8'h70, 3'b011, 3'b000, 8'h00);
    do_reset(); step(20);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre_err: got %b want 0", err); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h70) begin n_fail++; $display("FAIL ovf_jump: got %h want 70", ucode_addr); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err); end
    step(1);
    n_cmp++; if (ucode_addr !== 8'h41) begin n_fail++; $display("FAIL ovf_ret: got %h want 41", ucode_addr); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_rst_err: got %b want 0", err); end
    n_cmp++; if (ucode_addr !== 8'h00) begin n_fail++; $display("FAIL async_rst_addr: got %h want 00", ucode_addr); end
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_dispatch();
    fill_next();
    mem[3] = mk(3, 3'b100, 3'b001, 8'h80);
    ir = 16'b10011_000_0000_0000;
    status = 5'b00000;
    do_reset(); step(4);
    n_cmp++; if (ucode_addr !== 8'h93) begin n_fail++; $display("FAIL dispatch: got %h want 93", ucode_addr); end
    mem[3] = mk(3, 3'b100, 3'b000, 8'hF0);
    ir = 16'b11111_000_0000_0000;
    do_reset(); step(4);
    n_cmp++; if (ucode_addr !== 8'h0F) begin n_fail++; $display("FAIL dispatch_wrap: got %h want 0f", ucode_addr); end
    ir = '0;
  endtask

  task automatic test_wait_stall();
    fill_next();
    mem[8'h22] = mk(8'h22, 3'b101, 3'b000, 8'h00);
    mem_ready = 1'b0;
    do_reset(); step(8'h22);
    n_cmp++; if (ucode_addr !== 8'h22) begin n_fail++; $display("FAIL wait_reach: got %h want 22", ucode_addr); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_cmp++; if (ucode_addr !== 8'h22) begin n_fail++; $display("FAIL wait_hold[%0d]: got %h want 22", i, ucode_addr); end
    end
    n_cmp++; if (ctrlword !== cw(8'h22)) begin n_fail++; $display("FAIL wait_ctrlword: got %h want %h", ctrlword, cw(8'h22)); end
    mem_ready = 1'b1; stall = 1'b1;
    step(1);
    n_cmp++; if (ucode_addr !== 8'h22) begin n_fail++; $display("FAIL stall_over_wait: got %h want 22", ucode_addr); end
    n_cmp++; if (ctrlword !== 20'h0) begin n_fail++; $display("FAIL stall_bubble_w: got %h want 0", ctrlword); end
    stall = 1'b0;
    step(1);
    n_cmp++; if (ucode_addr !== 8'h23) begin n_fail++; $display("FAIL wait_done: got %h want 23", ucode_addr); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      n_cmp++; if (ucode_addr !== 8'h23) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 23", i, ucode_addr); end
      n_cmp++; if (ctrlword !== 20'h0) begin n_fail++; $display("FAIL stall_bubble[%0d]: got %h want 0", i, ctrlword); end
    end
    stall = 1'b0;
    step(1);
    n_cmp++; if (ucode_addr !== 8'h24) begin n_fail++; $display("FAIL stall_resume: got %h want 24", ucode_addr); end
    n_cmp++; if (ctrlword !== cw(8'h23)) begin n_fail++; $display("FAIL stall_resume_cw: got %h want %h", ctrlword, cw(8'h23)); end
    mem_ready = 1'b0;
  endtask

  task automatic test_halt();
    fill_next();
    mem[7] = mk(7, 3'b110, 3'b000, 8'h00);
    do_reset(); step(7);
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_pre: got %b want 0", halted); end
    step(1);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_rise: got %b want 1", halted); end
    step(5);
    n_cmp++; if (ucode_addr !== 8'h07) begin n_fail++; $display("FAIL halt_hold: got %h want 07", ucode_addr); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_stay: got %b want 1", halted); end
    n_cmp++; if (ctrlword !== cw(7)) begin n_fail++; $display("FAIL halt_ctrlword: got %h want %h", ctrlword, cw(7)); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ucode_addr !== 8'h00) begin n_fail++; $display("FAIL halt_rst_addr: got %h want 00", ucode_addr); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_rst_halted: got %b want 0", halted); end
    step(1);
    rst = 1'b0;
    step(2);
    n_cmp++; if (ucode_addr !== 8'h02) begin n_fail++; $display("FAIL post_halt_run: got %h want 02", ucode_addr); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1; ir = '0; status = '0; mem_ready = 1'b0; stall = 1'b0;
    test_reset();
    test_branch();
    test_call_ret();
    test_dispatch();
    test_wait_stall();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
